// File: rtl/sram_dp.sv
// sram_dp: address/write/read/control registers driving a single-port async SRAM
module sram_dp #(
    parameter int DW = 8,
    parameter int AW = 8,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    input  logic          a_wen_,
    input  logic          wd_wen_,
    input  logic          rd_wen_,
    input  logic          ctrl_wen_,
    input  logic          inca,
    output logic [AW-1:0] sram_addr,
    output logic [DW-1:0] sram_wdata,
    output logic          sram_we_,
    output logic          sram_oe_,
    input  logic [DW-1:0] sram_rdata,
    output logic [DW-1:0] rdata,
    output logic          rdata_vld,
    output logic [DW-1:0] ctrl_out,
    output logic [CW-1:0] wr_cnt
);
    // Protect bit as it will stand during the write cycle that a wd_wen_ load schedules
    logic prot_next;
    assign prot_next = !ctrl_wen_ ? din[0] : ctrl_out[0];
    assign sram_oe_ = rd_wen_ && sram_we_;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sram_addr  <= '0;
            sram_wdata <= '0;
            sram_we_   <= 1'b1;
            rdata      <= '0;
            rdata_vld  <= 1'b0;
            ctrl_out   <= '0;
            wr_cnt     <= '0;
        end else begin
            sram_addr  <= !a_wen_ ? din[AW-1:0] : sram_addr + AW'(inca);
            sram_wdata <= !wd_wen_ ? din : sram_wdata;
            sram_we_   <= wd_wen_ || prot_next;
            rdata      <= !rd_wen_ ? sram_rdata : rdata;
            rdata_vld  <= !rd_wen_;
            ctrl_out   <= !ctrl_wen_ ? din : ctrl_out;
            wr_cnt     <= (!sram_we_ && !(&wr_cnt)) ? wr_cnt + CW'(1) : wr_cnt;
        end
    end
endmodule

// File: tb/tb_sram_dp.sv
// tb_sram_dp: directed and random checks of sram_dp against a transaction-level model
module tb_sram_dp;
    logic       clk = 0, rst = 1;
    logic [7:0] din = 0;
    logic       a_wen_ = 1, wd_wen_ = 1, rd_wen_ = 1, ctrl_wen_ = 1, inca = 0;
    logic [7:0] sram_addr, sram_wdata, sram_rdata, rdata, ctrl_out;
    logic       sram_we_, sram_oe_, rdata_vld;
    logic [15:0] wr_cnt;
    logic [7:0] sram_addr2, sram_wdata2, rdata2, ctrl_out2;
    logic       sram_we2_, sram_oe2_, rdata_vld2;
    logic [1:0] wr_cnt2;
    logic [7:0] sram [256];
    logic [7:0] ref_mem [256];
    logic [7:0] m_addr, m_wdata, m_rdata, m_ctrl;
    logic       m_pend, m_vld;
    int         m_cnt, m_writes;
    int         checks = 0, errors = 0;

    always #5 clk = ~clk;

    sram_dp #(.DW(8), .AW(8), .CW(16)) u_dut (
        .clk(clk), .rst(rst), .din(din), .a_wen_(a_wen_), .wd_wen_(wd_wen_),
        .rd_wen_(rd_wen_), .ctrl_wen_(ctrl_wen_), .inca(inca),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_we_(sram_we_),
        .sram_oe_(sram_oe_), .sram_rdata(sram_rdata), .rdata(rdata),
        .rdata_vld(rdata_vld), .ctrl_out(ctrl_out), .wr_cnt(wr_cnt)
    );

    sram_dp #(.DW(8), .AW(8), .CW(2)) u_sat (
        .clk(clk), .rst(rst), .din(din), .a_wen_(a_wen_), .wd_wen_(wd_wen_),
        .rd_wen_(rd_wen_), .ctrl_wen_(ctrl_wen_), .inca(inca),
        .sram_addr(sram_addr2), .sram_wdata(sram_wdata2), .sram_we_(sram_we2_),
        .sram_oe_(sram_oe2_), .sram_rdata(sram_rdata), .rdata(rdata2),
        .rdata_vld(rdata_vld2), .ctrl_out(ctrl_out2), .wr_cnt(wr_cnt2)
    );

    // Asynchronous SRAM: combinational read, write committed at the end of a we_-low cycle
    assign sram_rdata = sram[sram_addr];
    always @(posedge clk) if (!sram_we_) sram[sram_addr] <= sram_wdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_addr = 0; m_wdata = 0; m_rdata = 0; m_ctrl = 0;
        m_pend = 0; m_vld = 0; m_cnt = 0; m_writes = 0;
    endtask

    function automatic logic m_we_();
        return !(m_pend && !m_ctrl[0]);
    endfunction

    task automatic check_state(input string tag);
        check({tag, ".addr"},  sram_addr, m_addr);
        check({tag, ".wdata"}, sram_wdata, m_wdata);
        check({tag, ".we_"},   sram_we_, m_we_());
        check({tag, ".rdata"}, rdata, m_rdata);
        check({tag, ".vld"},   rdata_vld, m_vld);
        check({tag, ".ctrl"},  ctrl_out, m_ctrl);
        check({tag, ".cnt"},   wr_cnt, m_cnt);
        check({tag, ".cnt2"},  wr_cnt2, (m_writes > 3) ? 3 : m_writes);
    endtask

    // One clock: drive at negedge, check oe_, apply model rules at the edge, check after it
    task automatic cyc(input logic a, wd, rd, ct, inc, input logic [7:0] d, input string tag);
        a_wen_ = a; wd_wen_ = wd; rd_wen_ = rd; ctrl_wen_ = ct; inca = inc; din = d;
        #1 check({tag, ".oe_"}, sram_oe_, rd && m_we_());
        @(posedge clk);
        if (!rd) m_rdata = ref_mem[m_addr];
        m_vld = !rd;
        if (!m_we_()) begin
            ref_mem[m_addr] = m_wdata;
            m_writes++;
            if (m_cnt < 65535) m_cnt++;
        end
        m_addr = !a ? d : m_addr + {7'b0, inc};
        m_pend = !wd;
        if (!wd) m_wdata = d;
        if (!ct) m_ctrl = d;
        @(negedge clk);
        check_state(tag);
    endtask

    task automatic idle(input string tag);
        cyc(1, 1, 1, 1, 0, 8'h00, tag);
    endtask

    initial begin
        int base, bad;
        logic a, wd, rd, ct, inc;
        for (int i = 0; i < 256; i++) begin sram[i] = 0; ref_mem[i] = 0; end
        model_reset();
        #12;
        check_state("reset");
        @(negedge clk) rst = 0;

        cyc(0, 1, 1, 1, 0, 8'h10, "t1.a");
        cyc(1, 0, 1, 1, 0, 8'hA5, "t1.wd");
        check("t1.we_", sram_we_, 0);
        check("t1.addr", sram_addr, 8'h10);
        check("t1.wdata", sram_wdata, 8'hA5);
        idle("t1.idle");
        check("t1.cnt", wr_cnt, 1);
        check("t1.mem", sram[8'h10], 8'hA5);

        base = m_cnt;
        cyc(0, 1, 1, 1, 0, 8'hFE, "t2.a");
        cyc(1, 0, 1, 1, 0, 8'h11, "t2.w1");
        cyc(1, 0, 1, 1, 1, 8'h22, "t2.w2");
        cyc(1, 0, 1, 1, 1, 8'h33, "t2.w3");
        cyc(1, 0, 1, 1, 1, 8'h44, "t2.w4");
        idle("t2.idle");
        check("t2.memFE", sram[8'hFE], 8'h11);
        check("t2.memFF", sram[8'hFF], 8'h22);
        check("t2.mem00", sram[8'h00], 8'h33);
        check("t2.mem01", sram[8'h01], 8'h44);
        check("t2.cnt", wr_cnt, base + 4);

        sram[8'h20] = 8'h3C; ref_mem[8'h20] = 8'h3C;
        cyc(0, 1, 1, 1, 0, 8'h20, "t3.a");
        rd_wen_ = 0;
        #1 check("t3.oe_", sram_oe_, 0);
        cyc(1, 1, 0, 1, 0, 8'h00, "t3.rd");
        check("t3.rdata", rdata, 8'h3C);
        check("t3.vld", rdata_vld, 1);
        idle("t3.idle");
        check("t3.vld_off", rdata_vld, 0);

        sram[8'h05] = 8'h5A; ref_mem[8'h05] = 8'h5A;
        base = m_cnt;
        cyc(1, 1, 1, 0, 0, 8'h01, "t4.prot");
        cyc(0, 1, 1, 1, 0, 8'h05, "t4.a");
        cyc(1, 0, 1, 1, 0, 8'h77, "t4.wd");
        check("t4.we_prot", sram_we_, 1);
        idle("t4.idle");
        check("t4.mem_prot", sram[8'h05], 8'h5A);
        check("t4.cnt_prot", wr_cnt, base);
        cyc(1, 1, 1, 0, 0, 8'h00, "t4.unprot");
        cyc(1, 0, 1, 1, 0, 8'h77, "t4.wd2");
        check("t4.we_open", sram_we_, 0);
        idle("t4.idle2");
        check("t4.mem_open", sram[8'h05], 8'h77);
        check("t4.cnt_open", wr_cnt, base + 1);
        check("t6.sat", wr_cnt2, 3);

        cyc(0, 1, 1, 1, 1, 8'h40, "t5.prio");
        check("t5.addr", sram_addr, 8'h40);
        sram[8'h40] = 8'hC3; ref_mem[8'h40] = 8'hC3;
        cyc(1, 0, 1, 1, 0, 8'h99, "t5.wd");
        rst = 1;
        #1 check("t5.we_rst", sram_we_, 1);
        check("t5.addr_rst", sram_addr, 0);
        check("t5.wdata_rst", sram_wdata, 0);
        check("t5.cnt_rst", wr_cnt, 0);
        check("t5.ctrl_rst", ctrl_out, 0);
        check("t5.rdata_rst", rdata, 0);
        @(posedge clk); #1;
        check("t5.mem_abort", sram[8'h40], 8'hC3);
        model_reset();
        @(negedge clk) rst = 0;
        check_state("t5.after");

        for (int n = 0; n < 400; n++) begin
            a   = ($urandom_range(0, 7) != 0);
            wd  = ($urandom_range(0, 2) == 0);
            ct  = ($urandom_range(0, 11) != 0);
            inc = ($urandom_range(0, 1) == 0);
            rd  = !m_we_() || ($urandom_range(0, 2) != 0);
            cyc(a, wd, rd, ct, inc, 8'($urandom), "rnd");
        end
        idle("rnd.flush");
        bad = 0;
        for (int i = 0; i < 256; i++) if (sram[i] !== ref_mem[i]) bad++;
        check("rnd.mem", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
